// File: rtl/siso_sched_pkg.sv
// rtl/siso_sched_pkg.sv - shared types and LTE block-length check for the SISO frame scheduler
package siso_sched_pkg;

    localparam int BLKLEN_W = 13;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FEED    = 2'd1,
        ST_DISCARD = 2'd2,
        ST_DRAIN   = 2'd3
    } sched_state_t;

    // LTE turbo interleaver sizes: four ranges, each with its own step.
    function automatic logic blklen_legal(input logic [BLKLEN_W-1:0] blklen);
        logic ok;
        ok = 1'b0;
        if (blklen >= 13'd40 && blklen <= 13'd512) begin
            ok = (blklen[2:0] == 3'd0);
        end else if (blklen >= 13'd528 && blklen <= 13'd1024) begin
            ok = (blklen[3:0] == 4'd0);
        end else if (blklen >= 13'd1056 && blklen <= 13'd2048) begin
            ok = (blklen[4:0] == 5'd0);
        end else if (blklen >= 13'd2112 && blklen <= 13'd6144) begin
            ok = (blklen[5:0] == 6'd0);
        end
        return ok;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker: first request at or after the pointer
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_gnt_valid,
    output logic [N-1:0]     o_gnt_onehot,
    output logic [IDX_W-1:0] o_gnt_idx
);

    int w_j;

    always_comb begin
        o_gnt_valid  = 1'b0;
        o_gnt_onehot = '0;
        o_gnt_idx    = '0;
        w_j          = 0;
        for (int i = 0; i < N; i++) begin
            w_j = (int'(i_ptr) + i) % N;
            if (!o_gnt_valid && i_req[w_j[IDX_W-1:0]]) begin
                o_gnt_valid                     = 1'b1;
                o_gnt_onehot[w_j[IDX_W-1:0]]    = 1'b1;
                o_gnt_idx                       = w_j[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/siso_frame_scheduler.sv
// rtl/siso_frame_scheduler.sv - shares one SISO decoder between N_REQ frame sources, one frame at a time
module siso_frame_scheduler
    import siso_sched_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 24,
    parameter int LLR_W       = 8,
    parameter int EXT_W       = 8,
    parameter int WDOG_CYCLES = 65535,
    parameter int TID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [N_REQ*BLKLEN_W-1:0] s_req_blklen,
    input  logic [N_REQ*DATA_W-1:0]   s_req_tdata,
    input  logic [N_REQ-1:0]          s_req_tvalid,
    input  logic [N_REQ-1:0]          s_req_tlast,
    output logic [N_REQ-1:0]          s_req_tready,
    output logic [BLKLEN_W-1:0]       dec_blklen,
    output logic [DATA_W-1:0]         dec_in_tdata,
    output logic                      dec_in_tvalid,
    output logic                      dec_in_tlast,
    input  logic                      dec_in_tready,
    input  logic [LLR_W-1:0]          dec_llr_tdata,
    input  logic                      dec_llr_tvalid,
    input  logic                      dec_llr_tuser,
    input  logic                      dec_llr_tlast,
    output logic                      dec_llr_tready,
    output logic [LLR_W-1:0]          m_llr_tdata,
    output logic                      m_llr_tvalid,
    output logic                      m_llr_tuser,
    output logic                      m_llr_tlast,
    output logic [TID_W-1:0]          m_llr_tid,
    input  logic                      m_llr_tready,
    input  logic [EXT_W-1:0]          dec_ext_tdata,
    input  logic                      dec_ext_tvalid,
    input  logic                      dec_ext_tuser,
    input  logic                      dec_ext_tlast,
    output logic [EXT_W-1:0]          m_ext_tdata,
    output logic                      m_ext_tvalid,
    output logic                      m_ext_tuser,
    output logic                      m_ext_tlast,
    output logic [TID_W-1:0]          m_ext_tid,
    output logic                      busy,
    output logic                      err_blklen,
    output logic                      err_timeout,
    output logic [TID_W-1:0]          err_id
);

    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    sched_state_t        r_state;
    logic [TID_W-1:0]    r_grant;
    logic [TID_W-1:0]    r_rr_ptr;
    logic [TID_W-1:0]    r_err_id;
    logic [BLKLEN_W-1:0] r_dec_blklen;
    logic                r_err_blklen;
    logic                r_err_timeout;
    logic                r_llr_done;
    logic                r_ext_done;
    logic [WDOG_W-1:0]   r_wdog;

    logic                w_gnt_valid;
    logic [N_REQ-1:0]    w_gnt_onehot;
    logic [TID_W-1:0]    w_gnt_idx;
    logic [BLKLEN_W-1:0] w_sel_blklen;
    logic                w_sel_legal;
    logic [DATA_W-1:0]   w_g_tdata;
    logic                w_g_tvalid;
    logic                w_g_tlast;
    logic                w_feed_last;
    logic                w_disc_last;
    logic                w_llr_done_nxt;
    logic                w_ext_done_nxt;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (TID_W)
    ) u_rr_arbiter (
        .i_req        (s_req_tvalid),
        .i_ptr        (r_rr_ptr),
        .o_gnt_valid  (w_gnt_valid),
        .o_gnt_onehot (w_gnt_onehot),
        .o_gnt_idx    (w_gnt_idx)
    );

    always_comb begin
        w_sel_blklen = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt_onehot[i]) begin
                w_sel_blklen = w_sel_blklen | s_req_blklen[i*BLKLEN_W +: BLKLEN_W];
            end
        end
    end

    assign w_sel_legal = blklen_legal(w_sel_blklen);

    assign w_g_tdata  = s_req_tdata[int'(r_grant)*DATA_W +: DATA_W];
    assign w_g_tvalid = s_req_tvalid[r_grant];
    assign w_g_tlast  = s_req_tlast[r_grant];

    // Input side is a pure mux of the granted requester; no skid buffering.
    always_comb begin
        s_req_tready  = '0;
        dec_in_tvalid = 1'b0;
        dec_in_tlast  = 1'b0;
        if (r_state == ST_FEED) begin
            s_req_tready[r_grant] = dec_in_tready;
            dec_in_tvalid         = w_g_tvalid;
            dec_in_tlast          = w_g_tlast;
        end else if (r_state == ST_DISCARD) begin
            s_req_tready[r_grant] = 1'b1;
        end
    end

    assign dec_in_tdata = w_g_tdata;

    assign w_feed_last    = (r_state == ST_FEED) && w_g_tvalid && dec_in_tready && w_g_tlast;
    assign w_disc_last    = (r_state == ST_DISCARD) && w_g_tvalid && w_g_tlast;
    assign w_llr_done_nxt = r_llr_done || (dec_llr_tvalid && m_llr_tready && dec_llr_tlast);
    assign w_ext_done_nxt = r_ext_done || (dec_ext_tvalid && dec_ext_tlast);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_rr_ptr      <= '0;
            r_err_id      <= '0;
            r_dec_blklen  <= '0;
            r_err_blklen  <= 1'b0;
            r_err_timeout <= 1'b0;
            r_llr_done    <= 1'b0;
            r_ext_done    <= 1'b0;
            r_wdog        <= '0;
        end else begin
            r_err_blklen  <= 1'b0;
            r_err_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_wdog     <= '0;
                    r_llr_done <= 1'b0;
                    r_ext_done <= 1'b0;
                    if (w_gnt_valid) begin
                        r_grant      <= w_gnt_idx;
                        r_dec_blklen <= w_sel_blklen;
                        r_rr_ptr     <= (w_gnt_idx == TID_W'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
                        if (w_sel_legal) begin
                            r_state <= ST_FEED;
                        end else begin
                            r_err_blklen <= 1'b1;
                            r_err_id     <= w_gnt_idx;
                            r_state      <= ST_DISCARD;
                        end
                    end
                end
                ST_FEED: begin
                    if (w_feed_last) begin
                        r_state <= ST_DRAIN;
                        r_wdog  <= WDOG_W'(1);
                    end
                end
                ST_DISCARD: begin
                    if (w_disc_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    r_llr_done <= w_llr_done_nxt;
                    r_ext_done <= w_ext_done_nxt;
                    // r_wdog holds the 1-based DRAIN cycle number; completion wins a tie.
                    if (w_llr_done_nxt && w_ext_done_nxt) begin
                        r_state <= ST_IDLE;
                    end else if (r_wdog == WDOG_W'(WDOG_CYCLES)) begin
                        r_state       <= ST_IDLE;
                        r_err_timeout <= 1'b1;
                        r_err_id      <= r_grant;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dec_blklen     = r_dec_blklen;
    assign dec_llr_tready = m_llr_tready;
    assign m_llr_tdata    = dec_llr_tdata;
    assign m_llr_tvalid   = dec_llr_tvalid;
    assign m_llr_tuser    = dec_llr_tuser;
    assign m_llr_tlast    = dec_llr_tlast;
    assign m_llr_tid      = r_grant;
    assign m_ext_tdata    = dec_ext_tdata;
    assign m_ext_tvalid   = dec_ext_tvalid;
    assign m_ext_tuser    = dec_ext_tuser;
    assign m_ext_tlast    = dec_ext_tlast;
    assign m_ext_tid      = r_grant;
    assign busy           = (r_state != ST_IDLE);
    assign err_blklen     = r_err_blklen;
    assign err_timeout    = r_err_timeout;
    assign err_id         = r_err_id;

endmodule

// File: tb/tb_siso_frame_scheduler.sv
// tb/tb_siso_frame_scheduler.sv - directed bench for the round-robin SISO frame scheduler
module tb_siso_frame_scheduler;

    localparam int N_REQ = 4, DATA_W = 24, LLR_W = 8, EXT_W = 8, WDOG_CYCLES = 100, TID_W = 2;

    logic                    aclk = 1'b0;
    logic                    aresetn = 1'b0;
    logic [N_REQ*13-1:0]     s_req_blklen = '0;
    logic [N_REQ*DATA_W-1:0] s_req_tdata = '0;
    logic [N_REQ-1:0]        s_req_tvalid = '0;
    logic [N_REQ-1:0]        s_req_tlast = '0;
    logic [N_REQ-1:0]        s_req_tready;
    logic [12:0]             dec_blklen;
    logic [DATA_W-1:0]       dec_in_tdata;
    logic                    dec_in_tvalid, dec_in_tlast;
    logic                    dec_in_tready = 1'b1;
    logic [LLR_W-1:0]        dec_llr_tdata = '0;
    logic                    dec_llr_tvalid = 1'b0, dec_llr_tuser = 1'b0, dec_llr_tlast = 1'b0;
    logic                    dec_llr_tready;
    logic [LLR_W-1:0]        m_llr_tdata;
    logic                    m_llr_tvalid, m_llr_tuser, m_llr_tlast;
    logic [TID_W-1:0]        m_llr_tid;
    logic                    m_llr_tready = 1'b1;
    logic [EXT_W-1:0]        dec_ext_tdata = '0;
    logic                    dec_ext_tvalid = 1'b0, dec_ext_tuser = 1'b0, dec_ext_tlast = 1'b0;
    logic [EXT_W-1:0]        m_ext_tdata;
    logic                    m_ext_tvalid, m_ext_tuser, m_ext_tlast;
    logic [TID_W-1:0]        m_ext_tid;
    logic                    busy, err_blklen, err_timeout;
    logic [TID_W-1:0]        err_id;

    siso_frame_scheduler #(
        .N_REQ(N_REQ), .DATA_W(DATA_W), .LLR_W(LLR_W), .EXT_W(EXT_W), .WDOG_CYCLES(WDOG_CYCLES)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_req_blklen(s_req_blklen), .s_req_tdata(s_req_tdata), .s_req_tvalid(s_req_tvalid),
        .s_req_tlast(s_req_tlast), .s_req_tready(s_req_tready),
        .dec_blklen(dec_blklen), .dec_in_tdata(dec_in_tdata), .dec_in_tvalid(dec_in_tvalid),
        .dec_in_tlast(dec_in_tlast), .dec_in_tready(dec_in_tready),
        .dec_llr_tdata(dec_llr_tdata), .dec_llr_tvalid(dec_llr_tvalid), .dec_llr_tuser(dec_llr_tuser),
        .dec_llr_tlast(dec_llr_tlast), .dec_llr_tready(dec_llr_tready),
        .m_llr_tdata(m_llr_tdata), .m_llr_tvalid(m_llr_tvalid), .m_llr_tuser(m_llr_tuser),
        .m_llr_tlast(m_llr_tlast), .m_llr_tid(m_llr_tid), .m_llr_tready(m_llr_tready),
        .dec_ext_tdata(dec_ext_tdata), .dec_ext_tvalid(dec_ext_tvalid), .dec_ext_tuser(dec_ext_tuser),
        .dec_ext_tlast(dec_ext_tlast),
        .m_ext_tdata(m_ext_tdata), .m_ext_tvalid(m_ext_tvalid), .m_ext_tuser(m_ext_tuser),
        .m_ext_tlast(m_ext_tlast), .m_ext_tid(m_ext_tid),
        .busy(busy), .err_blklen(err_blklen), .err_timeout(err_timeout), .err_id(err_id)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;
    bit dec_auto = 1'b1;
    bit tready_rand = 1'b0;
    bit abort = 1'b0;
    int cur_n = 0, cur_bad = 0, cur_id = 0, cur_blk = 0, tot_beats = 0;
    int fr_id[$], fr_len[$], fr_bad[$], fr_blk[$];
    int errb_cnt = 0, errb_id = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Beat payload is {requester, beat index} so the decoder-side monitor can verify order and owner.
    task automatic send_frame(input int r, input int blk, input int nbeats, input bit gaps,
                              output int first_wait);
        bit acc, ok;
        first_wait = 0;
        s_req_blklen[r*13 +: 13] = 13'(blk);
        for (int b = 0; b < nbeats; b++) begin
            if (gaps && ($urandom_range(0, 7) == 0)) begin
                s_req_tvalid[r] = 1'b0;
                tick();
            end
            s_req_tdata[r*DATA_W +: DATA_W] = {8'(r), 16'(b)};
            s_req_tvalid[r] = 1'b1;
            s_req_tlast[r]  = (b == nbeats - 1);
            ok = 1'b0;
            for (int w = 0; w < 20000; w++) begin
                @(negedge aclk);
                if (abort) break;
                acc = s_req_tready[r];
                tick();
                if (acc) begin
                    ok = 1'b1;
                    break;
                end
                if (b == 0) first_wait++;
            end
            if (abort) break;
            if (!ok) begin
                check("send_timeout", 32'(ok), 32'd1);
                break;
            end
        end
        s_req_tvalid[r] = 1'b0;
        s_req_tlast[r]  = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        @(negedge aclk);
        while (busy && w < 5000) begin
            @(negedge aclk);
            w++;
        end
        check("idle_reached", 32'(busy), 32'd0);
        tick();
    endtask

    task automatic check_frame(input int id, input int len, input int blk);
        if (fr_id.size() == 0) begin
            check("frame_present", 32'(fr_id.size()), 32'd1);
        end else begin
            check("frame_owner", 32'(fr_id.pop_front()), 32'(id));
            check("frame_beats", 32'(fr_len.pop_front()), 32'(len));
            check("frame_data_bad", 32'(fr_bad.pop_front()), 32'd0);
            check("frame_blklen", 32'(fr_blk.pop_front()), 32'(blk));
        end
    endtask

    initial forever begin
        @(posedge aclk);
        #1;
        dec_in_tready = tready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    initial forever begin
        @(negedge aclk);
        if (!aresetn) begin
            cur_n = 0;
            cur_bad = 0;
        end else if (dec_in_tvalid && dec_in_tready) begin
            if (cur_n == 0) begin
                cur_id  = int'(dec_in_tdata[23:16]);
                cur_blk = int'(dec_blklen);
            end
            if (int'(dec_in_tdata[15:0]) != cur_n || int'(dec_in_tdata[23:16]) != cur_id) cur_bad++;
            cur_n++;
            tot_beats++;
            if (dec_in_tlast) begin
                fr_id.push_back(cur_id);
                fr_len.push_back(cur_n);
                fr_bad.push_back(cur_bad);
                fr_blk.push_back(cur_blk);
                cur_n = 0;
                cur_bad = 0;
            end
        end
        if (err_blklen) begin
            errb_cnt++;
            errb_id = int'(err_id);
        end
    end

    // Stand-in decoder: two LLR and two extrinsic beats right after the input frame ends.
    initial begin
        int owner;
        logic [7:0] lv, ev;
        forever begin
            @(negedge aclk);
            if (aresetn && dec_auto && dec_in_tvalid && dec_in_tready && dec_in_tlast) begin
                owner = int'(dec_in_tdata[23:16]);
                tick();
                for (int k = 0; k < 2; k++) begin
                    lv = 8'(64 + 16 * k + owner);
                    ev = 8'(128 + 16 * k + owner);
                    dec_llr_tdata = lv; dec_llr_tvalid = 1'b1; dec_llr_tuser = (k == 0); dec_llr_tlast = (k == 1);
                    dec_ext_tdata = ev; dec_ext_tvalid = 1'b1; dec_ext_tuser = (k == 0); dec_ext_tlast = (k == 1);
                    @(negedge aclk);
                    check("llr_tid", 32'(m_llr_tid), 32'(owner));
                    check("ext_tid", 32'(m_ext_tid), 32'(owner));
                    check("llr_data", 32'(m_llr_tdata), 32'(lv));
                    check("ext_data", 32'(m_ext_tdata), 32'(ev));
                    tick();
                end
                dec_llr_tvalid = 1'b0; dec_llr_tuser = 1'b0; dec_llr_tlast = 1'b0;
                dec_ext_tvalid = 1'b0; dec_ext_tuser = 1'b0; dec_ext_tlast = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int fw0a, fw0b, fw1, fw2, fw3, fw, e0, b0, bcnt;

        // Reset state
        repeat (3) @(negedge aclk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tready", 32'(s_req_tready), 32'd0);
        check("rst_in_tvalid", 32'(dec_in_tvalid), 32'd0);
        check("rst_blklen", 32'(dec_blklen), 32'd0);
        check("rst_tid", 32'(m_llr_tid), 32'd0);
        check("rst_err_id", 32'(err_id), 32'd0);
        check("rst_err_pulses", 32'({err_blklen, err_timeout}), 32'd0);
        check("llr_tready_pass", 32'(dec_llr_tready), 32'd1);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        // All four requesters, blklen 40: grants 0,1,2,3 then 0 again
        fork
            begin send_frame(0, 40, 40, 1'b0, fw0a); send_frame(0, 40, 40, 1'b0, fw0b); end
            send_frame(1, 40, 40, 1'b0, fw1);
            send_frame(2, 40, 40, 1'b0, fw2);
            send_frame(3, 40, 40, 1'b0, fw3);
        join
        wait_idle();
        check("rr_first_latency", 32'(fw0a), 32'd1);
        check_frame(0, 40, 40);
        check_frame(1, 40, 40);
        check_frame(2, 40, 40);
        check_frame(3, 40, 40);
        check_frame(0, 40, 40);

        // Only req2, blklen 512 with input stalls from both sides
        tready_rand = 1'b1;
        send_frame(2, 512, 512, 1'b1, fw);
        wait_idle();
        tready_rand = 1'b0;
        check_frame(2, 512, 512);

        // Illegal blklen 41: discarded, error pulse, nothing reaches the decoder
        e0 = errb_cnt;
        b0 = tot_beats;
        send_frame(1, 41, 41, 1'b0, fw);
        wait_idle();
        check("discard_latency", 32'(fw), 32'd1);
        check("err_blklen_pulses", 32'(errb_cnt - e0), 32'd1);
        check("err_blklen_id", 32'(errb_id), 32'd1);
        check("discard_no_beats", 32'(tot_beats - b0), 32'd0);
        check("discard_frames", 32'(fr_id.size()), 32'd0);
        send_frame(3, 48, 48, 1'b0, fw);
        wait_idle();
        check("after_err_latency", 32'(fw), 32'd1);
        check_frame(3, 48, 48);
        check("err_id_held", 32'(err_id), 32'd1);
        check("no_new_err", 32'(errb_cnt - e0), 32'd1);

        // DRAIN completion: ext tlast five cycles before llr tlast
        dec_auto = 1'b0;
        send_frame(0, 40, 40, 1'b0, fw);
        check_frame(0, 40, 40);
        tick();
        tick();
        dec_ext_tdata = 8'h5A; dec_ext_tvalid = 1'b1; dec_ext_tuser = 1'b1; dec_ext_tlast = 1'b1;
        @(negedge aclk);
        check("ord_busy_ext", 32'(busy), 32'd1);
        check("ord_ext_data", 32'(m_ext_tdata), 32'h5A);
        check("ord_ext_tid", 32'(m_ext_tid), 32'd0);
        tick();
        dec_ext_tvalid = 1'b0; dec_ext_tuser = 1'b0; dec_ext_tlast = 1'b0;
        bcnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge aclk);
            if (busy) bcnt++;
            tick();
        end
        check("ord_busy_between", 32'(bcnt), 32'd4);
        dec_llr_tdata = 8'hC3; dec_llr_tvalid = 1'b1; dec_llr_tuser = 1'b1; dec_llr_tlast = 1'b1;
        @(negedge aclk);
        check("ord_busy_llr", 32'(busy), 32'd1);
        check("ord_llr_data", 32'(m_llr_tdata), 32'hC3);
        tick();
        dec_llr_tvalid = 1'b0; dec_llr_tuser = 1'b0; dec_llr_tlast = 1'b0;
        @(negedge aclk);
        check("ord_idle_after", 32'(busy), 32'd0);
        tick();

        // DRAIN completion: both tlasts in the same cycle
        send_frame(1, 40, 40, 1'b0, fw);
        check_frame(1, 40, 40);
        tick();
        dec_llr_tvalid = 1'b1; dec_llr_tuser = 1'b1; dec_llr_tlast = 1'b1;
        dec_ext_tvalid = 1'b1; dec_ext_tuser = 1'b1; dec_ext_tlast = 1'b1;
        @(negedge aclk);
        check("same_busy", 32'(busy), 32'd1);
        check("same_tid", 32'(m_llr_tid), 32'd1);
        tick();
        dec_llr_tvalid = 1'b0; dec_llr_tuser = 1'b0; dec_llr_tlast = 1'b0;
        dec_ext_tvalid = 1'b0; dec_ext_tuser = 1'b0; dec_ext_tlast = 1'b0;
        @(negedge aclk);
        check("same_idle", 32'(busy), 32'd0);
        tick();

        // Watchdog: decoder silent and downstream stalled
        m_llr_tready = 1'b0;
        send_frame(2, 40, 40, 1'b0, fw);
        check_frame(2, 40, 40);
        bcnt = 0;
        for (int k = 1; k <= WDOG_CYCLES; k++) begin
            @(negedge aclk);
            if (busy && !err_timeout) bcnt++;
            if (k == 1) check("wd_llr_tready", 32'(dec_llr_tready), 32'd0);
            tick();
        end
        check("wd_drain_cycles", 32'(bcnt), 32'(WDOG_CYCLES));
        @(negedge aclk);
        check("wd_err_timeout", 32'(err_timeout), 32'd1);
        check("wd_busy", 32'(busy), 32'd0);
        check("wd_err_id", 32'(err_id), 32'd2);
        tick();
        @(negedge aclk);
        check("wd_pulse_end", 32'(err_timeout), 32'd0);
        tick();
        m_llr_tready = 1'b1;
        dec_auto = 1'b1;

        // Async reset in the middle of a 6144 frame
        fork
            send_frame(2, 6144, 6144, 1'b0, fw);
            begin
                bcnt = 0;
                while (cur_n < 300 && bcnt < 20000) begin
                    @(negedge aclk);
                    #1;
                    bcnt++;
                end
                check("mid_frame_reached", 32'(cur_n >= 300), 32'd1);
                #2;
                aresetn = 1'b0;
                #1;
                check("arst_tready", 32'(s_req_tready), 32'd0);
                check("arst_in_tvalid", 32'(dec_in_tvalid), 32'd0);
                check("arst_busy", 32'(busy), 32'd0);
                check("arst_blklen", 32'(dec_blklen), 32'd0);
                abort = 1'b1;
                repeat (2) @(posedge aclk);
                #1;
                aresetn = 1'b1;
            end
        join
        abort = 1'b0;
        check("arst_no_frame", 32'(fr_id.size()), 32'd0);
        fork
            send_frame(3, 40, 40, 1'b0, fw3);
            send_frame(1, 40, 40, 1'b0, fw1);
        join
        wait_idle();
        check_frame(1, 40, 40);
        check_frame(3, 40, 40);
        tready_rand = 1'b1;
        send_frame(2, 6144, 6144, 1'b0, fw);
        wait_idle();
        tready_rand = 1'b0;
        check_frame(2, 6144, 6144);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
